// File: rtl/mfp_ahb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mfp_ahb_master_arbiter_pkg
//   Shared AHB-Lite constants used by the two-master arbiter: HTRANS
//   encodings, HRESP values, and the grant-selection helper applied at a
//   handover point.
// -----------------------------------------------------------------------------
package mfp_ahb_master_arbiter_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HRESP encodings (AHB-Lite, 1 bit)
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // A master is asking for the bus when it drives NONSEQ or SEQ.
   function automatic logic htrans_is_req(input logic [1:0] htrans);
      return htrans[1];
   endfunction

   // Next owner at a handover point. The current owner is idle there, so in
   // practice only the other master can be requesting; the tie-break is kept
   // so the choice stays well defined whatever the caller feeds in.
   function automatic logic arb_pick(input logic r0,
                                     input logic r1,
                                     input logic hp,
                                     input logic dflt);
      logic pick;
      if (r0 && r1)  pick = hp;
      else if (r0)   pick = 1'b0;
      else if (r1)   pick = 1'b1;
      else           pick = dflt;
      return pick;
   endfunction

endpackage

// File: rtl/mfp_ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// mfp_ahb_master_arbiter
//   Two-master AHB-Lite arbiter (M0 = CPU, M1 = serial loader) in front of a
//   single slave-side bus.
//
//   Ports
//     HCLK, HRESETn          clock, asynchronous active-low reset
//     Mx_H* (x = 0,1)        master address/control/write-data inputs
//     Mx_HREADY/HRESP/HRDATA per-master response outputs
//     S_H*  (outputs)        shared slave address/control/write data
//     S_HRDATA/HREADY/HRESP  slave response inputs
//     HMASTER                current address-phase owner
//
//   aowner_q owns the address phase and is also the grant FSM state.
//   downer_q/dvalid_q follow one accepted beat behind and steer write data
//   and the error response to the master whose data phase is in flight.
// -----------------------------------------------------------------------------
module mfp_ahb_master_arbiter
   import mfp_ahb_master_arbiter_pkg::*;
#(
   parameter logic DEFAULT_MASTER = 1'b0,
   parameter logic HIGH_PRIORITY  = 1'b1
)(
   input  logic        HCLK,
   input  logic        HRESETn,

   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic        M0_HMASTLOCK,
   input  logic [2:0]  M0_HSIZE,
   input  logic [2:0]  M0_HBURST,
   input  logic [3:0]  M0_HPROT,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   output logic [31:0] M0_HRDATA,

   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic        M1_HMASTLOCK,
   input  logic [2:0]  M1_HSIZE,
   input  logic [2:0]  M1_HBURST,
   input  logic [3:0]  M1_HPROT,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] M1_HRDATA,

   output logic [31:0] S_HADDR,
   output logic [1:0]  S_HTRANS,
   output logic        S_HWRITE,
   output logic [2:0]  S_HSIZE,
   output logic [2:0]  S_HBURST,
   output logic [3:0]  S_HPROT,
   output logic        S_HMASTLOCK,
   output logic [31:0] S_HWDATA,
   input  logic [31:0] S_HRDATA,
   input  logic        S_HREADY,
   input  logic        S_HRESP,

   output logic        HMASTER
);

   // Grant FSM states; the state value is the owning master's index.
   localparam logic [0:0] OWN0 = 1'b0;
   localparam logic [0:0] OWN1 = 1'b1;

   logic [0:0] aowner_q, aowner_d;
   logic       downer_q;
   logic       dvalid_q;

   logic       req0, req1;
   logic [1:0] own_htrans;
   logic       own_lock;
   logic       handover_ok;

   assign req0 = htrans_is_req(M0_HTRANS);
   assign req1 = htrans_is_req(M1_HTRANS);

   assign own_htrans = (aowner_q == OWN1) ? M1_HTRANS    : M0_HTRANS;
   assign own_lock   = (aowner_q == OWN1) ? M1_HMASTLOCK : M0_HMASTLOCK;

   // The grant may only move on an accepted IDLE from an unlocked owner: the
   // owner's last data phase is then empty, so it never loses the bus with
   // a transfer of its own still in flight. BUSY keeps the grant.
   assign handover_ok = S_HREADY && (own_htrans == HTRANS_IDLE) && !own_lock;

   always_comb begin
      aowner_d = aowner_q;
      if (handover_ok) begin
         aowner_d = arb_pick(req0, req1, HIGH_PRIORITY, DEFAULT_MASTER);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         aowner_q <= DEFAULT_MASTER;
         downer_q <= DEFAULT_MASTER;
         dvalid_q <= 1'b0;
      end else begin
         aowner_q <= aowner_d;
         // The address phase on the bus becomes the data phase once accepted.
         if (S_HREADY) begin
            downer_q <= aowner_q;
            dvalid_q <= S_HTRANS[1];
         end
      end
   end

   // Slave-side address/control: straight copy of the owner, so a
   // non-owner's request can never leak onto the bus.
   always_comb begin
      if (aowner_q == OWN1) begin
         S_HADDR     = M1_HADDR;
         S_HTRANS    = M1_HTRANS;
         S_HWRITE    = M1_HWRITE;
         S_HSIZE     = M1_HSIZE;
         S_HBURST    = M1_HBURST;
         S_HPROT     = M1_HPROT;
         S_HMASTLOCK = M1_HMASTLOCK;
      end else begin
         S_HADDR     = M0_HADDR;
         S_HTRANS    = M0_HTRANS;
         S_HWRITE    = M0_HWRITE;
         S_HSIZE     = M0_HSIZE;
         S_HBURST    = M0_HBURST;
         S_HPROT     = M0_HPROT;
         S_HMASTLOCK = M0_HMASTLOCK;
      end
   end

   // Write data belongs to the data phase, one beat behind the address.
   assign S_HWDATA = downer_q ? M1_HWDATA : M0_HWDATA;

   // Read data is broadcast; only the data-phase owner is listening for it.
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;

   // Responses reach only the master owning a real data phase, so an ERROR
   // cannot be seen by a master that has nothing outstanding.
   assign M0_HRESP = (dvalid_q && (downer_q == 1'b0)) ? S_HRESP : HRESP_OKAY;
   assign M1_HRESP = (dvalid_q && (downer_q == 1'b1)) ? S_HRESP : HRESP_OKAY;

   // Owner sees the slave's HREADY. A requesting non-owner is held off with
   // HREADY low; an idle non-owner sees HREADY high so it may start issuing.
   assign M0_HREADY = (aowner_q == OWN0) ? S_HREADY : !req0;
   assign M1_HREADY = (aowner_q == OWN1) ? S_HREADY : !req1;

   assign HMASTER = aowner_q[0];

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
module tb_mfp_ahb_master_arbiter;

   localparam logic [1:0] I = 2'b00;
   localparam logic [1:0] B = 2'b01;
   localparam logic [1:0] N = 2'b10;
   localparam logic [1:0] S = 2'b11;
   localparam int NV = 30;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;

   logic [31:0] M0_HADDR, M1_HADDR;
   logic [1:0]  M0_HTRANS, M1_HTRANS;
   logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
   logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
   logic [3:0]  M0_HPROT, M1_HPROT;
   logic [31:0] M0_HWDATA, M1_HWDATA;
   logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
   logic [31:0] M0_HRDATA, M1_HRDATA;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   logic [1:0]  S_HTRANS;
   logic        S_HWRITE, S_HMASTLOCK, S_HREADY, S_HRESP;
   logic [2:0]  S_HSIZE, S_HBURST;
   logic [3:0]  S_HPROT;
   logic        HMASTER;

   mfp_ahb_master_arbiter #(.DEFAULT_MASTER(1'b0), .HIGH_PRIORITY(1'b1)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
      .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
      .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
      .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
      .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
      .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
      .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
      .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
      .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
      .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT),
      .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA),
      .S_HREADY(S_HREADY), .S_HRESP(S_HRESP), .HMASTER(HMASTER)
   );

   always #5 HCLK = ~HCLK;

   // One row = one bus cycle: stimulus, then expected address owner (hm),
   // expected data-phase owner (ds), per-master HREADY and HRESP.
   typedef struct {
      logic [1:0]  t0;
      logic [31:0] a0;
      logic [1:0]  t1;
      logic [31:0] a1;
      logic        l1;
      logic        rdy;
      logic        resp;
      logic        hm;
      logic        ds;
      logic        r0;
      logic        r1;
      logic        e0;
      logic        e1;
   } vec_t;

   vec_t tv [NV];
   int checks = 0;
   int failures = 0;

   function automatic vec_t mk(input logic [1:0] t0, input logic [31:0] a0,
                               input logic [1:0] t1, input logic [31:0] a1,
                               input logic l1, input logic rdy, input logic resp,
                               input logic hm, input logic ds,
                               input logic r0, input logic r1,
                               input logic e0, input logic e1);
      vec_t v;
      v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.l1 = l1;
      v.rdy = rdy; v.resp = resp; v.hm = hm; v.ds = ds;
      v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   initial begin
      //             t0 a0            t1 a1            l1 rdy rsp hm ds r0 r1 e0 e1
      // single CPU read at the boot vector, then idle
      tv[0]  = mk(N, 32'h1FC00000, I, 32'h0,        0, 1, 0,  0, 0, 1, 1, 0, 0);
      tv[1]  = mk(I, 32'h1FC00004, I, 32'h0,        0, 1, 1,  0, 0, 1, 1, 1, 0);
      // CPU streams while loader waits, one slave wait state, then handover
      tv[2]  = mk(N, 32'h100,      N, 32'h200,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[3]  = mk(S, 32'h104,      N, 32'h200,      0, 0, 0,  0, 0, 0, 0, 0, 0);
      tv[4]  = mk(S, 32'h104,      N, 32'h200,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[5]  = mk(I, 32'h108,      N, 32'h200,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      // locked loader burst, two wait states, an IDLE gap; CPU requesting
      tv[6]  = mk(N, 32'h300,      N, 32'h200,      1, 1, 0,  1, 0, 0, 1, 0, 0);
      tv[7]  = mk(N, 32'h300,      S, 32'h204,      1, 0, 0,  1, 1, 0, 0, 0, 0);
      tv[8]  = mk(N, 32'h300,      S, 32'h204,      1, 0, 0,  1, 1, 0, 0, 0, 0);
      tv[9]  = mk(N, 32'h300,      S, 32'h204,      1, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[10] = mk(N, 32'h300,      I, 32'h208,      1, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[11] = mk(N, 32'h300,      N, 32'h208,      1, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[12] = mk(N, 32'h300,      S, 32'h20C,      1, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[13] = mk(N, 32'h300,      I, 32'h210,      0, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[14] = mk(N, 32'h300,      I, 32'h210,      0, 1, 0,  0, 1, 1, 1, 0, 0);
      tv[15] = mk(I, 32'h304,      I, 32'h210,      0, 1, 0,  0, 0, 1, 1, 0, 0);
      // loader write gets a two-cycle ERROR, then the bus parks on M0
      tv[16] = mk(I, 32'h304,      N, 32'h400,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[17] = mk(I, 32'h304,      N, 32'h400,      0, 1, 0,  1, 0, 1, 1, 0, 0);
      tv[18] = mk(I, 32'h304,      I, 32'h404,      0, 0, 1,  1, 1, 1, 0, 0, 1);
      tv[19] = mk(I, 32'h304,      I, 32'h404,      0, 1, 1,  1, 1, 1, 1, 0, 1);
      tv[20] = mk(I, 32'h304,      I, 32'h404,      0, 1, 0,  0, 1, 1, 1, 0, 0);
      // both start NONSEQ together from an idle bus parked on M0
      tv[21] = mk(N, 32'h500,      N, 32'h600,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[22] = mk(I, 32'h504,      N, 32'h600,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[23] = mk(N, 32'h504,      N, 32'h600,      0, 1, 0,  1, 0, 0, 1, 0, 0);
      tv[24] = mk(N, 32'h504,      I, 32'h604,      0, 1, 0,  1, 1, 0, 1, 0, 0);
      tv[25] = mk(N, 32'h504,      I, 32'h604,      0, 1, 0,  0, 1, 1, 1, 0, 0);
      // BUSY beat keeps the grant; no response routed behind a BUSY
      tv[26] = mk(B, 32'h508,      N, 32'h700,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[27] = mk(S, 32'h508,      N, 32'h700,      0, 1, 1,  0, 0, 1, 0, 0, 0);
      tv[28] = mk(I, 32'h50C,      N, 32'h700,      0, 1, 0,  0, 0, 1, 0, 0, 0);
      tv[29] = mk(I, 32'h50C,      N, 32'h700,      0, 1, 0,  1, 0, 1, 1, 0, 0);

      M0_HADDR = 32'h0; M0_HTRANS = I; M0_HWRITE = 1'b0; M0_HMASTLOCK = 1'b0;
      M0_HSIZE = 3'd2;  M0_HBURST = 3'd0; M0_HPROT = 4'h3; M0_HWDATA = 32'h0;
      M1_HADDR = 32'h0; M1_HTRANS = N; M1_HWRITE = 1'b1; M1_HMASTLOCK = 1'b1;
      M1_HSIZE = 3'd0;  M1_HBURST = 3'd3; M1_HPROT = 4'h1; M1_HWDATA = 32'h0;
      S_HRDATA = 32'h0; S_HREADY = 1'b1; S_HRESP = 1'b1;

      // in reset: M1 asks and the slave shows ERROR, yet nothing is routed
      repeat (2) @(negedge HCLK);
      #1;
      chk("reset HMASTER", {31'd0, HMASTER}, 32'd0);
      chk("reset M0_HRESP", {31'd0, M0_HRESP}, 32'd0);
      chk("reset M1_HRESP", {31'd0, M1_HRESP}, 32'd0);
      chk("reset M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
      chk("reset S_HMASTLOCK", {31'd0, S_HMASTLOCK}, 32'd0);
      M1_HTRANS = I; M1_HMASTLOCK = 1'b0; S_HRESP = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         logic [31:0] w0, w1, rd;
         @(negedge HCLK);
         w0 = {16'hA0A0, 16'(i)};
         w1 = {16'hB1B1, 16'(i)};
         rd = {16'hC0DE, 16'(i)};
         M0_HTRANS = tv[i].t0; M0_HADDR = tv[i].a0; M0_HWDATA = w0;
         M1_HTRANS = tv[i].t1; M1_HADDR = tv[i].a1; M1_HWDATA = w1;
         M1_HMASTLOCK = tv[i].l1;
         S_HREADY = tv[i].rdy; S_HRESP = tv[i].resp; S_HRDATA = rd;
         #1;
         chk($sformatf("v%0d HMASTER", i),    {31'd0, HMASTER}, {31'd0, tv[i].hm});
         chk($sformatf("v%0d S_HADDR", i),    S_HADDR, tv[i].hm ? tv[i].a1 : tv[i].a0);
         chk($sformatf("v%0d S_HTRANS", i),   {30'd0, S_HTRANS}, {30'd0, tv[i].hm ? tv[i].t1 : tv[i].t0});
         chk($sformatf("v%0d S_HWRITE", i),   {31'd0, S_HWRITE}, {31'd0, tv[i].hm});
         chk($sformatf("v%0d S_HBURST", i),   {29'd0, S_HBURST}, tv[i].hm ? 32'd3 : 32'd0);
         chk($sformatf("v%0d S_HSIZE", i),    {29'd0, S_HSIZE}, tv[i].hm ? 32'd0 : 32'd2);
         chk($sformatf("v%0d S_HPROT", i),    {28'd0, S_HPROT}, tv[i].hm ? 32'd1 : 32'd3);
         chk($sformatf("v%0d S_HMASTLOCK", i), {31'd0, S_HMASTLOCK}, {31'd0, tv[i].hm & tv[i].l1});
         chk($sformatf("v%0d S_HWDATA", i),   S_HWDATA, tv[i].ds ? w1 : w0);
         chk($sformatf("v%0d M0_HREADY", i),  {31'd0, M0_HREADY}, {31'd0, tv[i].r0});
         chk($sformatf("v%0d M1_HREADY", i),  {31'd0, M1_HREADY}, {31'd0, tv[i].r1});
         chk($sformatf("v%0d M0_HRESP", i),   {31'd0, M0_HRESP}, {31'd0, tv[i].e0});
         chk($sformatf("v%0d M1_HRESP", i),   {31'd0, M1_HRESP}, {31'd0, tv[i].e1});
         chk($sformatf("v%0d M0_HRDATA", i),  M0_HRDATA, rd);
         chk($sformatf("v%0d M1_HRDATA", i),  M1_HRDATA, rd);
      end

      // Loader mid-burst with an ERROR pending, then reset pulsed between
      // clock edges: grant and response must drop without waiting for a clock.
      @(negedge HCLK);
      M1_HTRANS = S; M1_HADDR = 32'h704; S_HREADY = 1'b0; S_HRESP = 1'b1;
      #1;
      chk("burst HMASTER", {31'd0, HMASTER}, 32'd1);
      chk("burst M1_HRESP", {31'd0, M1_HRESP}, 32'd1);
      #1 HRESETn = 1'b0;
      #1;
      chk("async HMASTER", {31'd0, HMASTER}, 32'd0);
      chk("async S_HADDR", S_HADDR, 32'h50C);
      chk("async S_HTRANS", {30'd0, S_HTRANS}, 32'd0);
      chk("async M1_HRESP", {31'd0, M1_HRESP}, 32'd0);
      chk("async M0_HRESP", {31'd0, M0_HRESP}, 32'd0);
      chk("async M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      M1_HTRANS = I; S_HREADY = 1'b1; S_HRESP = 1'b1;
      #1;
      chk("post HMASTER", {31'd0, HMASTER}, 32'd0);
      chk("post M1_HRESP", {31'd0, M1_HRESP}, 32'd0);
      chk("post M0_HRESP", {31'd0, M0_HRESP}, 32'd0);
      chk("post M1_HREADY", {31'd0, M1_HREADY}, 32'd1);
      chk("post M0_HREADY", {31'd0, M0_HREADY}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
